// File: rtl/ct_clint_pkg.sv
// rtl/ct_clint_pkg.sv - shared constants, types and decode helper for the N-hart CLINT
// Purpose: register map bases, per-hart strides, APB privilege encodings, region
//          enum and FSM state enum used by ct_clint_nhart_func and ct_clint_hart_regs.
// Ports:   none (package).
package ct_clint_pkg;

  localparam int MAX_HART = 16;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] SSIP_BASE     = 16'hC000;
  localparam logic [15:0] STIMECMP_BASE = 16'hD000;

  localparam int SIP_STRIDE  = 4;
  localparam int TCMP_STRIDE = 8;

  localparam logic [1:0] PPROT_M = 2'b11;
  localparam logic [1:0] PPROT_S = 2'b01;
  localparam logic [1:0] PPROT_U = 2'b00;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_SSIP,
    REG_STIMECMP
  } region_e;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } apb_state_e;

  // True when off lies in [base, base + span).
  function automatic logic in_window(input logic [15:0] off, input logic [15:0] base,
                                     input int span);
    return ({1'b0, off} >= {1'b0, base}) && ({1'b0, off} < ({1'b0, base} + 17'(span)));
  endfunction

endpackage

// File: rtl/ct_clint_hart_regs.sv
// rtl/ct_clint_hart_regs.sv - one hart's CLINT registers, compare flops and read mux
// Purpose: holds msip/mtimecmp (and ssip/stimecmp when CT_CLINT_STIMER_EN is defined),
//          produces the hart's interrupt lines and its slice of the read data.
// Ports:   clk, rst (sync active-high); sel (hart addressed), we (commit write),
//          region/hi/wdata (decoded access), mtime (system time);
//          rdata (0 unless sel), ms_int, mt_int, ss_int, st_int.
module ct_clint_hart_regs
  import ct_clint_pkg::*;
#(
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  region_e     region,
  input  logic        hi,
  input  logic [31:0] wdata,
  input  logic [63:0] mtime,
  output logic [31:0] rdata,
  output logic        ms_int,
  output logic        mt_int,
  output logic        ss_int,
  output logic        st_int
);

  logic        msip_q;
  logic [63:0] mtimecmp_q;

  // The compare sees the register value before any write landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= MTIMECMP_RST;
      mt_int     <= 1'b0;
    end else begin
      mt_int <= (mtime >= mtimecmp_q);
      if (we && region == REG_MSIP) begin
        msip_q <= wdata[0];
      end
      if (we && region == REG_MTIMECMP) begin
        if (hi) mtimecmp_q[63:32] <= wdata;
        else    mtimecmp_q[31:0]  <= wdata;
      end
    end
  end

  assign ms_int = msip_q;

`ifdef CT_CLINT_STIMER_EN
  logic        ssip_q;
  logic [63:0] stimecmp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ssip_q     <= 1'b0;
      stimecmp_q <= MTIMECMP_RST;
      st_int     <= 1'b0;
    end else begin
      st_int <= (mtime >= stimecmp_q);
      if (we && region == REG_SSIP) begin
        ssip_q <= wdata[0];
      end
      if (we && region == REG_STIMECMP) begin
        if (hi) stimecmp_q[63:32] <= wdata;
        else    stimecmp_q[31:0]  <= wdata;
      end
    end
  end

  assign ss_int = ssip_q;
`else
  assign ss_int = 1'b0;
  assign st_int = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (region)
        REG_MSIP:     rdata = {31'b0, msip_q};
        REG_MTIMECMP: rdata = hi ? mtimecmp_q[63:32] : mtimecmp_q[31:0];
`ifdef CT_CLINT_STIMER_EN
        REG_SSIP:     rdata = {31'b0, ssip_q};
        REG_STIMECMP: rdata = hi ? stimecmp_q[63:32] : stimecmp_q[31:0];
`endif
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/ct_clint_nhart_func.sv
// rtl/ct_clint_nhart_func.sv - N-hart CLINT: APB decode, response FSM, per-hart registers
// Purpose: APB slave for per-hart msip/mtimecmp (ssip/stimecmp with CT_CLINT_STIMER_EN),
//          one wait state, privilege/decode error reporting, per-hart interrupt vectors.
// Ports:   forever_cpuclk, cpurst (sync active-high); apb_clk_en, psel_clint, penable,
//          paddr, pwrite, pwdata, pprot (APB request); prdata_clint, pready_clint,
//          perr_clint (APB response); sysio_clint_mtime (system time);
//          clint_ms_int/mt_int/ss_int/st_int [NUM_HART] (interrupts).
// Config:  CT_CLINT_STIMER_EN enables the supervisor software/timer registers.
module ct_clint_nhart_func
  import ct_clint_pkg::*;
#(
  parameter int          NUM_HART     = 4,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                apb_clk_en,
  input  logic                psel_clint,
  input  logic                penable,
  input  logic [31:0]         paddr,
  input  logic                pwrite,
  input  logic [31:0]         pwdata,
  input  logic [1:0]          pprot,
  output logic [31:0]         prdata_clint,
  output logic                pready_clint,
  output logic                perr_clint,
  input  logic [63:0]         sysio_clint_mtime,
  output logic [NUM_HART-1:0] clint_ms_int,
  output logic [NUM_HART-1:0] clint_mt_int,
  output logic [NUM_HART-1:0] clint_ss_int,
  output logic [NUM_HART-1:0] clint_st_int
);

  localparam logic [4:0] NUM_HART_W = 5'(NUM_HART);

  apb_state_e    state_q, state_d;
  logic          accept;
  logic [15:0]   off;
  region_e       dec_region;
  logic [3:0]    dec_hart;
  logic          dec_hi;
  logic          is_m, is_s, priv_err, hart_oob, dec_err;
  logic          wr_commit;
  logic [31:0]   rd_merge;
  logic [31:0]   rd_q;
  logic          err_q;
  logic [NUM_HART-1:0] hart_sel;
  logic [31:0]   hart_rdata [NUM_HART];
  logic          unused_paddr_hi;

  assign unused_paddr_hi = ^paddr[31:16];
  assign off = paddr[15:0];

  // Region bases are aligned to their window size, so the hart index and the
  // timer half select come straight from the offset bits.
  always_comb begin
    dec_region = REG_NONE;
    dec_hart   = '0;
    dec_hi     = 1'b0;
    if (in_window(off, MSIP_BASE, MAX_HART * SIP_STRIDE)) begin
      dec_region = REG_MSIP;
      dec_hart   = off[5:2];
    end else if (in_window(off, MTIMECMP_BASE, MAX_HART * TCMP_STRIDE)) begin
      dec_region = REG_MTIMECMP;
      dec_hart   = off[6:3];
      dec_hi     = off[2];
    end
`ifdef CT_CLINT_STIMER_EN
    else if (in_window(off, SSIP_BASE, MAX_HART * SIP_STRIDE)) begin
      dec_region = REG_SSIP;
      dec_hart   = off[5:2];
    end else if (in_window(off, STIMECMP_BASE, MAX_HART * TCMP_STRIDE)) begin
      dec_region = REG_STIMECMP;
      dec_hart   = off[6:3];
      dec_hi     = off[2];
    end
`endif
  end

  assign is_m     = (dec_region == REG_MSIP) || (dec_region == REG_MTIMECMP);
  assign is_s     = (dec_region == REG_SSIP) || (dec_region == REG_STIMECMP);
  assign priv_err = (is_m && pprot != PPROT_M) || (is_s && pprot == PPROT_U);
  assign hart_oob = ({1'b0, dec_hart} >= NUM_HART_W);
  assign dec_err  = (paddr[1:0] != 2'b00) || (dec_region == REG_NONE) || hart_oob || priv_err;

  assign accept    = (state_q == ST_IDLE) && apb_clk_en && psel_clint && penable;
  assign wr_commit = accept && pwrite && !dec_err;

  // FSM: state register
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs; response fields are only visible during RESP
  always_comb begin
    pready_clint = 1'b0;
    prdata_clint = '0;
    perr_clint   = 1'b0;
    if (state_q == ST_RESP) begin
      pready_clint = 1'b1;
      prdata_clint = rd_q;
      perr_clint   = err_q;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rd_q  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      rd_q  <= (dec_err || pwrite) ? 32'b0 : rd_merge;
      err_q <= dec_err;
    end
  end

  always_comb begin
    rd_merge = '0;
    for (int i = 0; i < NUM_HART; i++) begin
      rd_merge = rd_merge | hart_rdata[i];
    end
  end

  for (genvar g = 0; g < NUM_HART; g++) begin : g_hart
    assign hart_sel[g] = (dec_hart == 4'(g));

    ct_clint_hart_regs #(
      .MTIMECMP_RST(MTIMECMP_RST)
    ) u_hart (
      .clk    (forever_cpuclk),
      .rst    (cpurst),
      .sel    (hart_sel[g]),
      .we     (wr_commit && hart_sel[g]),
      .region (dec_region),
      .hi     (dec_hi),
      .wdata  (pwdata),
      .mtime  (sysio_clint_mtime),
      .rdata  (hart_rdata[g]),
      .ms_int (clint_ms_int[g]),
      .mt_int (clint_mt_int[g]),
      .ss_int (clint_ss_int[g]),
      .st_int (clint_st_int[g])
    );
  end

endmodule

// File: tb/tb_ct_clint_nhart_func.sv
// tb/tb_ct_clint_nhart_func.sv - self-checking bench for ct_clint_nhart_func
module tb_ct_clint_nhart_func;

  localparam int NH = 4;
`ifdef CT_CLINT_STIMER_EN
  localparam bit S_EN = 1'b1;
`else
  localparam bit S_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic [31:0]   paddr = '0;
  logic          pwrite = 1'b0;
  logic [31:0]   pwdata = '0;
  logic [1:0]    pprot = 2'b11;
  logic [63:0]   mtime = '0;
  logic [31:0]   prdata;
  logic          pready;
  logic          perr;
  logic [NH-1:0] ms, mt, ss, st;

  int checks = 0;
  int failures = 0;

  // Reference state
  bit          m_msip [NH];
  bit          m_ssip [NH];
  logic [63:0] m_mcmp [NH];
  logic [63:0] m_scmp [NH];

  always #5 clk = ~clk;

  ct_clint_nhart_func #(
    .NUM_HART(NH),
    .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .forever_cpuclk   (clk),
    .cpurst           (rst),
    .apb_clk_en       (clk_en),
    .psel_clint       (psel),
    .penable          (penable),
    .paddr            (paddr),
    .pwrite           (pwrite),
    .pwdata           (pwdata),
    .pprot            (pprot),
    .prdata_clint     (prdata),
    .pready_clint     (pready),
    .perr_clint       (perr),
    .sysio_clint_mtime(mtime),
    .clint_ms_int     (ms),
    .clint_mt_int     (mt),
    .clint_ss_int     (ss),
    .clint_st_int     (st)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NH; i++) begin
      m_msip[i] = 1'b0;
      m_ssip[i] = 1'b0;
      m_mcmp[i] = '1;
      m_scmp[i] = '1;
    end
  endfunction

  // kind: 0 none, 1 msip, 2 mtimecmp, 3 ssip, 4 stimecmp
  function automatic void model_decode(input logic [31:0] a, output int kind, output int h,
                                       output bit hi);
    int o;
    o = {16'b0, a[15:0]};
    kind = 0; h = 0; hi = 1'b0;
    if (o < 'h40) begin
      kind = 1; h = o / 4;
    end else if (o >= 'h4000 && o < 'h4080) begin
      kind = 2; h = (o - 'h4000) / 8; hi = ((o % 8) >= 4);
    end else if (S_EN && o >= 'hC000 && o < 'hC040) begin
      kind = 3; h = (o - 'hC000) / 4;
    end else if (S_EN && o >= 'hD000 && o < 'hD080) begin
      kind = 4; h = (o - 'hD000) / 8; hi = ((o % 8) >= 4);
    end
  endfunction

  function automatic void model_access(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                                       input logic [1:0] prot, output bit e,
                                       output logic [31:0] rd);
    int kind, h;
    bit hi;
    model_decode(a, kind, h, hi);
    e  = (a % 4 != 0) || kind == 0 || h >= NH ||
         ((kind == 1 || kind == 2) && prot != 2'b11) ||
         ((kind == 3 || kind == 4) && prot == 2'b00);
    rd = '0;
    if (e) return;
    if (wr) begin
      case (kind)
        1: m_msip[h] = wd[0];
        2: if (hi) m_mcmp[h][63:32] = wd; else m_mcmp[h][31:0] = wd;
        3: m_ssip[h] = wd[0];
        4: if (hi) m_scmp[h][63:32] = wd; else m_scmp[h][31:0] = wd;
        default: ;
      endcase
    end else begin
      case (kind)
        1: rd = {31'b0, m_msip[h]};
        2: rd = hi ? m_mcmp[h][63:32] : m_mcmp[h][31:0];
        3: rd = {31'b0, m_ssip[h]};
        4: rd = hi ? m_scmp[h][63:32] : m_scmp[h][31:0];
        default: ;
      endcase
    end
  endfunction

  task automatic check_ints(input string tag);
    logic [NH-1:0] ems, emt, ess, est;
    for (int h = 0; h < NH; h++) begin
      ems[h] = m_msip[h];
      emt[h] = (mtime >= m_mcmp[h]);
      ess[h] = S_EN && m_ssip[h];
      est[h] = S_EN && (mtime >= m_scmp[h]);
    end
    check({tag, "_ms"}, 64'(ms), 64'(ems));
    check({tag, "_mt"}, 64'(mt), 64'(emt));
    check({tag, "_ss"}, 64'(ss), 64'(ess));
    check({tag, "_st"}, 64'(st), 64'(est));
  endtask

  // One APB transfer; checks the single-cycle response strobe and idle-time zeros.
  task automatic do_op(input string tag, input logic [31:0] a, input bit wr,
                       input logic [31:0] wd, input logic [1:0] prot);
    logic [31:0] rd_obs, rd_exp;
    logic        er_obs;
    bit          er_exp;
    @(negedge clk);
    paddr = a; pwrite = wr; pwdata = wd; pprot = prot;
    psel = 1'b1; penable = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    check({tag, "_pready"}, 64'(pready), 64'(1));
    rd_obs = prdata;
    er_obs = perr;
    model_access(a, wr, wd, prot, er_exp, rd_exp);
    check({tag, "_perr"}, 64'(er_obs), 64'(er_exp));
    if (!wr) check({tag, "_prdata"}, 64'(rd_obs), 64'(rd_exp));
    @(posedge clk); #1;
    check({tag, "_idle_pready"}, 64'(pready), 64'(0));
    check({tag, "_idle_prdata"}, 64'(prdata), 64'(0));
  endtask

  function automatic logic [31:0] rand_addr();
    int cat, h;
    logic [15:0] o;
    cat = $urandom_range(0, 9);
    h   = $urandom_range(0, 5);
    case (cat)
      0, 1, 2: o = 16'(h * 4);
      3, 4, 5: o = 16'h4000 + 16'(h * 8 + 4 * $urandom_range(0, 1));
      6:       o = 16'hC000 + 16'(h * 4);
      7:       o = 16'hD000 + 16'(h * 8 + 4 * $urandom_range(0, 1));
      8:       o = 16'(h * 4 + $urandom_range(1, 3));
      default: o = 16'($urandom_range(0, 65535)) & 16'hFFFC;
    endcase
    return {16'($urandom), o};
  endfunction

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  prot;
    int          p;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_pready", 64'(pready), 64'(0));
    check("reset_perr", 64'(perr), 64'(0));
    check("reset_prdata", 64'(prdata), 64'(0));
    check_ints("reset");
    for (int h = 0; h < NH; h++) begin
      do_op("rst_cmp_lo", 32'h4000 + 32'(h * 8), 1'b0, 32'h0, 2'b11);
      do_op("rst_cmp_hi", 32'h4004 + 32'(h * 8), 1'b0, 32'h0, 2'b11);
    end

    // msip write to hart 2
    do_op("msip2_wr", 32'h0000_0008, 1'b1, 32'h0000_0001, 2'b11);
    check("msip2_vec", 64'(ms), 64'(4'b0100));
    check_ints("msip2");
    do_op("msip2_rd", 32'h0000_0008, 1'b0, 32'h0, 2'b11);
    do_op("msip2_hi_bits", 32'h0000_0008, 1'b1, 32'hFFFF_FFFE, 2'b11);
    do_op("msip2_rd0", 32'h0000_0008, 1'b0, 32'h0, 2'b11);

    // mtimecmp[1] = 0x100, mtime ramps across it
    do_op("cmp1_lo", 32'h0000_4008, 1'b1, 32'h0000_0100, 2'b11);
    do_op("cmp1_hi", 32'h0000_400C, 1'b1, 32'h0000_0000, 2'b11);
    for (int v = 'hFE; v <= 'h101; v++) begin
      @(negedge clk);
      mtime = 64'(v);
      @(posedge clk); #1;
      check("ramp_mt1", 64'(mt[1]), 64'(v >= 'h100));
    end
    check_ints("ramp");

    // privilege, alignment and decode errors
    do_op("s_wr_mcmp", 32'h0000_4000, 1'b1, 32'h0000_0055, 2'b01);
    do_op("mcmp0_rd", 32'h0000_4000, 1'b0, 32'h0, 2'b11);
    do_op("oob_hart4", 32'h0000_0010, 1'b0, 32'h0, 2'b11);
    do_op("misalign", 32'h0000_0002, 1'b0, 32'h0, 2'b11);
    do_op("unmapped", 32'h0000_8000, 1'b0, 32'h0, 2'b11);
    do_op("u_rd_msip", 32'h0000_0000, 1'b0, 32'h0, 2'b00);
    do_op("ssip_u", 32'h0000_C000, 1'b1, 32'h1, 2'b00);
    do_op("ssip_s", 32'h0000_C000, 1'b1, 32'h1, 2'b01);
    do_op("stcmp_s", 32'h0000_D000, 1'b1, 32'h0, 2'b01);
    check_ints("err_block");

    // apb_clk_en low: no accept
    @(negedge clk);
    paddr = 32'h0; pwrite = 1'b1; pwdata = 32'h1; pprot = 2'b11;
    psel = 1'b1; penable = 1'b1; clk_en = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("clken_low_pready", 64'(pready), 64'(0));
    end
    psel = 1'b0; penable = 1'b0; clk_en = 1'b1;
    check_ints("clken_low");

    // mtime wrap with a zero compare on hart 2
    do_op("cmp2_lo0", 32'h0000_4010, 1'b1, 32'h0, 2'b11);
    do_op("cmp2_hi0", 32'h0000_4014, 1'b1, 32'h0, 2'b11);
    @(negedge clk); mtime = '1;
    @(posedge clk); #1;
    check_ints("wrap_max");
    @(negedge clk); mtime = '0;
    @(posedge clk); #1;
    check_ints("wrap_zero");

    // reset coinciding with a transfer: dropped, not committed
    @(negedge clk);
    paddr = 32'h0000_C004; pwrite = 1'b1; pwdata = 32'h1; pprot = 2'b11;
    psel = 1'b1; penable = 1'b1; clk_en = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    model_reset();
    check("rst_xfer_pready", 64'(pready), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_xfer_pready2", 64'(pready), 64'(0));
    check("rst_xfer_ss", 64'(ss), 64'(0));
    check_ints("rst_xfer");
    do_op("rst_xfer_ssip_rd", 32'h0000_C004, 1'b0, 32'h0, 2'b11);

    // randomized traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      a    = rand_addr();
      p    = $urandom_range(0, 7);
      prot = (p < 4) ? 2'(p) : 2'b11;
      wd   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2)) : 32'($urandom);
      do_op("rand", a, 1'($urandom_range(0, 1)), wd, prot);
      check_ints("rand_op");
      @(negedge clk);
      mtime = {32'($urandom_range(0, 1)), 32'($urandom)};
      @(posedge clk); #1;
      check_ints("rand_time");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
